vga_scanout: RTL
================

Name: vga_scanout

Overview:
Consumer end of the pixel-write stream produced by the drawing blocks (writeEn/x/y/colour). Stores writes into a 320x240x3 framebuffer and continuously reads it back in raster order. Each framebuffer pixel is doubled horizontally and vertically to drive a 640x480@60 VGA DAC. Sits between the top-level drawing mux and the board VGA pins.

Parameters:
FB_W, 320, framebuffer width in pixels
FB_H, 240, framebuffer height in pixels
H_VIS/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixel ticks (total 800)
V_VIS/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines (total 525)

Ports:
clock  in  1  50 MHz system clock
resetn  in  1  asynchronous active-low reset
writeEn  in  1  pixel write strobe, one write per clock
x  in  9  write column
y  in  8  write row
colour  in  3  write colour {r,g,b}
oob_seen  out  1  sticky: a write with x>=FB_W or y>=FB_H was dropped
frame_start  out  1  one-clock pulse at start of each frame (v and h counters both wrap to 0)
vga_clk  out  1  25 MHz pixel clock to DAC
vga_hs  out  1  hsync, active low
vga_vs  out  1  vsync, active low
vga_blank_n  out  1  low outside visible area
vga_sync_n  out  1  tied 0
vga_r/vga_g/vga_b  out  8 each  colour bit replicated 8 times

Behaviour:
- Reset (async, resetn=0): h_cnt=0, v_cnt=0, pix_en=0, vga_clk=0, vga_hs=1, vga_vs=1, vga_blank_n=0, rgb=0, frame_start=0, oob_seen=0. Framebuffer contents are not cleared.
- pix_en toggles every clock. The first pix_en=1 occurs on the 2nd clock after reset release.
- vga_clk = ~pix_en, registered, so outputs change on the falling edge of vga_clk.
- Counters advance only when pix_en=1:
  - h_cnt 0..799, wraps to 0.
  - v_cnt increments when h_cnt wraps; 0..524, wraps to 0.
- frame_start pulses for one clock on the pix_en edge where h_cnt 799->0 and v_cnt 524->0.
- Write port (every clock, independent of pix_en):
  - If writeEn and x<320 and y<240: write colour at addr = y*320+x, computed as (y<<8)+(y<<6)+x, 17 bits, max 76799.
  - If writeEn and out of range: no write; oob_seen<=1 and stays 1 until reset.
  - writeEn=0: no write.
- Read port:
  - On each pix_en edge, read address = (v_cnt>>1)*320 + (h_cnt>>1) when visible (h_cnt<640, v_cnt<480); otherwise address 0.
  - RAM read latency is 1 clock. Data is stable before the next pix_en.
- Output stage, on each pix_en edge, registers from the previous tick's counter values:
  - blank_n = visible
  - hs = !(656 <= h < 752)
  - vs = !(490 <= v < 492)
  - rgb = visible ? {8{q[2]}},{8{q[1]}},{8{q[0]}} : 0
  - Total latency: 1 pixel tick (2 clocks) from counter value to pins.
- Read-during-write to the same address: read returns the old data; the write completes. There is no stall and no back-pressure; the writer may stream at one pixel per clock.
- Reset mid-frame restarts timing at (0,0) immediately. A write in flight in the reset cycle is discarded.

Decomposition:
- Package vga_pkg holds: timing constants, FB_W/FB_H, the address-width constant (17), and the colour-bit index constants R=2, G=1, B=0.
- Sub-module fb_ram:
  - Simple dual-port, 76800x3, one write port and one registered read port, old-data on collision.
  - Inferable as block RAM.
- vga_scanout contains the timing counters, address arithmetic, write filtering and output pipeline.

Test Plan:
- Reset release, no writes -> first pix_en on clock 2; frame_start on clock 2*800*525 = 840000 after the first tick; vga_hs low for 96 ticks starting at h=656 (+1 tick latency); vga_vs low for exactly 2 lines.
- Write x=0,y=0,colour=3'b100, then x=319,y=239,colour=3'b011 -> at visible (0,0),(1,0),(0,1),(1,1) vga_r=8'hFF, g=b=0; at (638..639, 478..479) r=0, g=b=8'hFF.
- Write x=320,y=0 and x=0,y=240 with writeEn=1 -> oob_seen=1, no framebuffer location changed (read back address 0 and 319 unchanged), oob_seen remains 1 after 10 further valid writes.
- Continuous writes of all 76800 pixels at one per clock with colour=(x^y)&7, concurrent with scanout -> the next full frame matches the expected pattern at every doubled pixel; blanking intervals show rgb=0 and blank_n=0.
- Write to the address being read on the same clock -> that tick shows the old colour; the next frame shows the new colour.
- Assert resetn=0 asynchronously mid-line (h=300,v=100) -> outputs go to reset values without a clock edge; after release, timing restarts from h=0,v=0 and framebuffer contents are retained.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants, types and address helper for the VGA scanout path.
// Holds 640x480@60 timing, framebuffer geometry and colour-bit indices.
package vga_pkg;

  localparam int FB_W = 320;
  localparam int FB_H = 240;
  localparam int FB_DEPTH = FB_W * FB_H;
  localparam int ADDR_W = 17;

  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;

  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;

  localparam int R = 2;
  localparam int G = 1;
  localparam int B = 0;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [2:0] colour_t;

  typedef struct packed {
    logic vis;
    logic hs;
    logic vs;
  } tmg_t;

  // row*320 + col as two shifts and an add
  function automatic addr_t fb_addr(
    input logic [8:0] col,
    input logic [7:0] row
  );
    addr_t rw;
    rw = {9'd0, row};
    return (rw << 8) + (rw << 6) + {8'd0, col};
  endfunction

endpackage

// File: rtl/fb_ram.sv
// 76800x3 simple dual-port framebuffer, registered read, old data on collision.
// Ports: clock, we/waddr/wdata write port, re/raddr read port, q read data.
module fb_ram
  import vga_pkg::*;
(
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [2:0]        wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [2:0]        q
);

  colour_t mem [FB_DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/vga_scanout.sv
// Framebuffer write filter plus 640x480 raster scanout with 2x pixel doubling.
// Ports: clock/resetn, writeEn/x/y/colour in; oob_seen, frame_start, vga_* out.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int V_VISIBLE = V_VIS,
  parameter int V_FRONT   = V_FP,
  parameter int V_SYNCW   = V_SYNC,
  parameter int V_BACK    = V_BP
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       writeEn,
  input  logic [8:0] x,
  input  logic [7:0] y,
  input  logic [2:0] colour,
  output logic       oob_seen,
  output logic       frame_start,
  output logic       vga_clk,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNCW + V_BACK;

  localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
  localparam logic [9:0] H_END  = 10'(H_VIS);
  localparam logic [9:0] V_END  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_ON  = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_OFF = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_ON  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_OFF = 10'(V_VISIBLE + V_FRONT + V_SYNCW);

  localparam tmg_t TMG_RST = '{vis: 1'b0, hs: 1'b1, vs: 1'b1};

  logic       pix_en;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_wrap;
  logic       v_wrap;
  logic       visible;
  tmg_t       tmg;
  tmg_t       stage;
  addr_t      rd_addr;
  addr_t      wr_addr;
  logic       in_range;
  logic       we;
  colour_t    q;

  assign vga_sync_n = 1'b0;

  assign h_wrap  = (h_cnt == H_LAST);
  assign v_wrap  = (v_cnt == V_LAST);
  assign visible = (h_cnt < H_END) && (v_cnt < V_END);

  assign tmg.vis = visible;
  assign tmg.hs  = !((h_cnt >= HS_ON) && (h_cnt < HS_OFF));
  assign tmg.vs  = !((v_cnt >= VS_ON) && (v_cnt < VS_OFF));

  // Blanking reads park on address 0; the data is masked at the output.
  assign rd_addr = visible ? fb_addr(h_cnt[9:1], v_cnt[8:1]) : '0;

  assign in_range = (x < 9'(FB_W)) && (y < 8'(FB_H));
  assign wr_addr  = fb_addr(x, y);
  // Gating with resetn drops a write that lands in a reset cycle.
  assign we       = resetn && writeEn && in_range;

  fb_ram u_fb (
    .clock (clock),
    .we    (we),
    .waddr (wr_addr),
    .wdata (colour),
    .re    (pix_en),
    .raddr (rd_addr),
    .q     (q)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pix_en      <= 1'b0;
      vga_clk     <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      stage       <= TMG_RST;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      frame_start <= 1'b0;
      oob_seen    <= 1'b0;
    end else begin
      pix_en      <= ~pix_en;
      vga_clk     <= ~pix_en;
      frame_start <= pix_en && h_wrap && v_wrap;
      if (writeEn && !in_range) oob_seen <= 1'b1;
      if (pix_en) begin
        h_cnt <= h_wrap ? '0 : h_cnt + 10'd1;
        if (h_wrap) v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;
        // stage holds this tick's timing while the RAM fetches its pixel
        stage       <= tmg;
        vga_blank_n <= stage.vis;
        vga_hs      <= stage.hs;
        vga_vs      <= stage.vs;
        vga_r       <= stage.vis ? {8{q[R]}} : '0;
        vga_g       <= stage.vis ? {8{q[G]}} : '0;
        vga_b       <= stage.vis ? {8{q[B]}} : '0;
      end
    end
  end

endmodule
